// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bundle for prog_loader.
// Host drives the stream (master); the loader is the slave.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wd;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses LEN/DATA/CHK byte stream into
// program memory writes and owns the CPU reset line.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wd_q, mem_wd_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rdy;
  logic              xfer;
  logic [15:0]       n_w;
  logic [16:0]       cnt_inc;

  // Stream acceptance is purely a function of the state.
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      S_LEN_H, S_LEN_L,
      S_DATA_H, S_DATA_L,
      S_CHK:   rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  assign xfer         = bus.in_valid && rdy;
  assign bus.in_ready = rdy;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign err          = err_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    n_w         = {len_q[15:8], bus.in_data};
    cnt_inc     = cnt_q + 17'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_H;
          len_d   = '0;
          cnt_d   = '0;
          chk_d   = '0;
        end
      end
      S_LEN_H: begin
        if (xfer) begin
          len_d[15:8] = bus.in_data;
          chk_d       = chk_q ^ bus.in_data;
          state_d     = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (xfer) begin
          len_d[7:0] = bus.in_data;
          chk_d      = chk_q ^ bus.in_data;
          if ({1'b0, n_w} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_w == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_H;
          end
        end
      end
      S_DATA_H: begin
        if (xfer) begin
          hi_d    = bus.in_data;
          chk_d   = chk_q ^ bus.in_data;
          state_d = S_DATA_L;
        end
      end
      S_DATA_L: begin
        if (xfer) begin
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q[ADDR_W-1:0];
          mem_wd_d   = {hi_q, bus.in_data};
          cnt_d      = cnt_inc;
          chk_d      = chk_q ^ bus.in_data;
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_H;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.in_data == chk_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_LEN_H;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_reset_d = 1'b1;
          len_d       = '0;
          cnt_d       = '0;
          chk_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset also kills a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (ADDR_W = 4).
// Directed table, corner sequences and random loads.
module tb_prog_loader;
  localparam int AW = 4;
  localparam int CAPW = 1 << AW;

  typedef logic [AW+15:0] wr_t;

  typedef struct {
    string      name;
    logic [7:0] b [8];
    int         nb;
    int         mode;
    int         e_done;
    int         e_err;
    int         nwr;
    wr_t        w0;
    wr_t        w1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, err;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_q [$];
  wr_t wr_q [$];
  wr_t exp_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Capture each write pulse; the CPU must be held in reset.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_q.push_back({bus.mem_addr, bus.mem_wd});
      total++;
      if (!cpu_reset) begin
        bad++;
        $display("FAIL we_cpu_reset actual=0 required=1");
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int nb, input int mode);
    int  i = 0;
    int  t = 0;
    bit  ph = 1'b0;
    while (i < nb && t < 400) begin
      @(negedge clk);
      ph = !ph;
      if (mode == 0) bus.in_valid = 1'b1;
      else if (mode == 1) bus.in_valid = ph;
      else bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = tx_q[i];
      if (bus.in_valid && bus.in_ready) i++;
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("send_bytes", i, nb);
  endtask

  // Writes, flags and handshake after a completed/failed load.
  task automatic check_load(input string nm, input int e_done,
                            input int e_err);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk({nm, "_wr"}, int'(wr_q[i]), int'(exp_q[i]));
    chk({nm, "_done"}, int'(done), e_done);
    chk({nm, "_err"}, int'(err), e_err);
    chk({nm, "_cpurst"}, int'(cpu_reset), e_done ? 0 : 1);
    chk({nm, "_rdy"}, int'(bus.in_ready), 0);
    wr_q.delete();
    exp_q.delete();
  endtask

  // Reference: decode the stream by its format rules.
  task automatic model(output int nsend, output int e_done,
                       output int e_err);
    int n;
    logic [7:0] x;
    n = {tx_q[0], tx_q[1]};
    exp_q.delete();
    if (n > CAPW) begin
      nsend = 2; e_done = 0; e_err = 1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < 2 + 2 * n; k++) x ^= tx_q[k];
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a;
      a = AW'(k);
      exp_q.push_back({a, tx_q[2 + 2*k], tx_q[3 + 2*k]});
    end
    nsend = 3 + 2 * n;
    e_done = (tx_q[2 + 2*n] == x) ? 1 : 0;
    e_err = 1 - e_done;
  endtask

  vec_t tbl [6];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    tbl[0] = '{"single", '{8'h00,8'h01,8'h12,8'h34,8'h27,0,0,0},
               5, 0, 1, 0, 1, {4'h0,16'h1234}, '0};
    tbl[1] = '{"two_bp", '{8'h00,8'h02,8'h80,8'h05,8'hC0,8'h10,8'h57,0},
               7, 1, 1, 0, 2, {4'h0,16'h8005}, {4'h1,16'hC010}};
    tbl[2] = '{"badchk", '{8'h00,8'h01,8'h12,8'h34,8'h26,0,0,0},
               5, 0, 0, 1, 1, {4'h0,16'h1234}, '0};
    tbl[3] = '{"oversz", '{8'h00,8'h11,0,0,0,0,0,0},
               2, 0, 0, 1, 0, '0, '0};
    tbl[4] = '{"zero", '{8'h00,8'h00,8'h00,0,0,0,0,0},
               3, 0, 1, 0, 0, '0, '0};
    tbl[5] = '{"after0", '{8'h00,8'h01,8'hAB,8'hCD,8'h67,0,0,0},
               5, 2, 1, 0, 1, {4'h0,16'hABCD}, '0};

    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", int'(cpu_reset), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_we", int'(bus.mem_we), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wd", int'(bus.mem_wd), 0);
    chk("rst_rdy", int'(bus.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rdy", int'(bus.in_ready), 0);

    for (int v = 0; v < 6; v++) begin
      tx_q.delete();
      for (int k = 0; k < tbl[v].nb; k++) tx_q.push_back(tbl[v].b[k]);
      if (tbl[v].nwr > 0) exp_q.push_back(tbl[v].w0);
      if (tbl[v].nwr > 1) exp_q.push_back(tbl[v].w1);
      pulse_start();
      send(tbl[v].nb, tbl[v].mode);
      check_load(tbl[v].name, tbl[v].e_done, tbl[v].e_err);
    end

    // Reset lands on the DATA_L transfer edge.
    tx_q = '{8'h00, 8'h02, 8'hAA};
    pulse_start();
    send(3, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hBB;
    reset = 1'b1;
    @(negedge clk);
    chk("rml_we", int'(bus.mem_we), 0);
    chk("rml_rdy", int'(bus.in_ready), 0);
    chk("rml_cpurst", int'(cpu_reset), 1);
    chk("rml_addr", int'(bus.mem_addr), 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rml_nwr", wr_q.size(), 0);
    chk("rml_idle_rdy", int'(bus.in_ready), 0);
    wr_q.delete();

    // Start pulse during DATA_H must not disturb the load.
    tx_q = '{8'h00, 8'h02, 8'h11, 8'h22};
    pulse_start();
    send(4, 0);
    pulse_start();
    chk("sig_rdy", int'(bus.in_ready), 1);
    tx_q = '{8'h33, 8'h44, 8'h46};
    send(3, 0);
    exp_q.push_back({4'h0, 16'h1122});
    exp_q.push_back({4'h1, 16'h3344});
    check_load("start_ign", 1, 0);

    // Random loads against the stream-format model.
    for (int it = 0; it < 24; it++) begin
      int n, ns, ed, ee, md;
      logic [7:0] x, r;
      if (it == 0) n = CAPW;
      else if ($urandom_range(0, 5) == 0) n = $urandom_range(CAPW + 1, 65535);
      else n = $urandom_range(0, CAPW);
      tx_q.delete();
      tx_q.push_back(8'(n >> 8));
      tx_q.push_back(8'(n));
      if (n <= CAPW) begin
        for (int k = 0; k < 2 * n; k++) begin
          r = 8'($urandom);
          tx_q.push_back(r);
        end
        x = 8'h00;
        foreach (tx_q[k]) x ^= tx_q[k];
        if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        tx_q.push_back(x);
      end
      model(ns, ed, ee);
      md = $urandom_range(0, 2);
      pulse_start();
      send(ns, md);
      check_load("rand", ed, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
